sim_uart_xcvr: RTL and testbench



---
 rtl/sim_uart_xcvr.sv | 249 ++++++++++++++++++++++++
 tb/tb_sim_uart_xcvr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_uart_xcvr.sv
// 8N1 UART transceiver with RTS/CTS flow control, a small receive FIFO and
// one-cycle frame-error / overrun pulses.
module sim_uart_xcvr #(
   parameter int unsigned CLKS_PER_BIT  = 87,
   parameter int unsigned RX_FIFO_DEPTH = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_uart_cts_n,
   input  logic       i_uart_rxd,
   output logic       o_uart_rts_n,
   output logic       o_uart_txd,
   input  logic       i_tx_valid,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_ready,
   output logic       o_rx_valid,
   output logic [7:0] o_rx_data,
   input  logic       i_rx_ready,
   output logic       o_rx_frame_err,
   output logic       o_rx_overrun
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam int unsigned PtrW = $clog2(RX_FIFO_DEPTH);
   localparam logic [CntW-1:0] BitEnd    = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfEnd   = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [PtrW:0]   RtsLevel  = (PtrW + 1)'(RX_FIFO_DEPTH - 1);
   localparam logic [PtrW:0]   FullLevel = (PtrW + 1)'(RX_FIFO_DEPTH);

   typedef enum logic [2:0] {TxIdle, TxWaitCts, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   logic [1:0] rxd_sync_q, cts_sync_q;
   logic       rxd_prev_q;
   logic       rxd_s, cts_n_s, rxd_fall;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rxd_sync_q <= 2'b11;
         cts_sync_q <= 2'b11;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_sync_q <= {rxd_sync_q[0], i_uart_rxd};
         cts_sync_q <= {cts_sync_q[0], i_uart_cts_n};
         rxd_prev_q <= rxd_sync_q[1];
      end
   end

   assign rxd_s    = rxd_sync_q[1];
   assign cts_n_s  = cts_sync_q[1];
   assign rxd_fall = rxd_prev_q & ~rxd_s;

   // ---------------- transmitter ----------------
   tx_state_e       tx_state_q, tx_state_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            txd_q, txd_d;
   logic            tx_ready_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = 1'b1;
      unique case (tx_state_q)
         TxIdle: begin
            if (i_tx_valid && tx_ready_q) begin
               tx_shift_d = i_tx_data;
               tx_state_d = TxWaitCts;
            end
         end
         TxWaitCts: begin
            if (!cts_n_s) begin
               tx_cnt_d   = '0;
               tx_state_d = TxStart;
            end
         end
         TxStart: begin
            txd_d = 1'b0;
            if (tx_cnt_q == BitEnd) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TxData;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxData: begin
            txd_d = tx_shift_q[0];
            if (tx_cnt_q == BitEnd) begin
               tx_cnt_d   = '0;
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
               if (tx_bit_q == 3'd7) tx_state_d = TxStop;
               else                  tx_bit_d   = tx_bit_q + 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TxStop: begin
            if (tx_cnt_q == BitEnd) begin
               tx_cnt_d   = '0;
               tx_state_d = TxIdle;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = TxIdle;
      endcase
   end

   // txd is registered from the current state, so the line lags the FSM by one cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
         tx_ready_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         tx_ready_q <= (tx_state_d == TxIdle);
      end
   end

   // ---------------- receiver ----------------
   rx_state_e       rx_state_q, rx_state_d;
   logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rx_push, rx_pop, fifo_full;
   logic            frame_err_q, frame_err_d, overrun_q, overrun_d;

   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_push     = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            if (rxd_fall) begin
               rx_cnt_d   = '0;
               rx_state_d = RxStart;
            end
         end
         RxStart: begin
            if (rx_cnt_q == HalfEnd) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rxd_s ? RxIdle : RxData;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxData: begin
            if (rx_cnt_q == BitEnd) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_s, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
               else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         RxStop: begin
            if (rx_cnt_q == BitEnd) begin
               rx_cnt_d   = '0;
               rx_state_d = RxIdle;
               // A pop in the same cycle frees a slot, so a full FIFO can still take the byte.
               if (!rxd_s)                    frame_err_d = 1'b1;
               else if (fifo_full && !rx_pop) overrun_d   = 1'b1;
               else                           rx_push     = 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_state_q  <= RxIdle;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_shift_q  <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_shift_q  <= rx_shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // ---------------- receive FIFO ----------------
   logic [7:0]      fifo_mem_q [RX_FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]   fifo_cnt_q, fifo_cnt_d;
   logic            rts_n_q;

   assign fifo_full = (fifo_cnt_q == FullLevel);
   assign rx_pop    = o_rx_valid & i_rx_ready;

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (rx_push && !rx_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
      else if (!rx_push && rx_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         rts_n_q    <= 1'b1;
      end else begin
         if (rx_push) begin
            fifo_mem_q[wr_ptr_q] <= rx_shift_q;
            wr_ptr_q             <= wr_ptr_q + 1'b1;
         end
         if (rx_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         fifo_cnt_q <= fifo_cnt_d;
         rts_n_q    <= (fifo_cnt_q >= RtsLevel);
      end
   end

   assign o_uart_txd     = txd_q;
   assign o_tx_ready     = tx_ready_q;
   assign o_uart_rts_n   = rts_n_q;
   assign o_rx_valid     = (fifo_cnt_q != '0);
   assign o_rx_data      = fifo_mem_q[rd_ptr_q];
   assign o_rx_frame_err = frame_err_q;
   assign o_rx_overrun   = overrun_q;

endmodule

// File: tb/tb_sim_uart_xcvr.sv
// Self-checking bench for sim_uart_xcvr: scoreboard queues for TX and RX bytes,
// cycle-exact checks on TX framing, CTS gating, RTS and the error pulses.
module tb_sim_uart_xcvr;

   localparam int unsigned Cpb   = 8;
   localparam int unsigned Depth = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cts_n, rxd, rts_n, txd;
   logic       tx_valid, tx_ready, rx_valid, rx_ready, frame_err, overrun;
   logic [7:0] tx_data, rx_data;

   sim_uart_xcvr #(
      .CLKS_PER_BIT (Cpb),
      .RX_FIFO_DEPTH(Depth)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_uart_cts_n  (cts_n),
      .i_uart_rxd    (rxd),
      .o_uart_rts_n  (rts_n),
      .o_uart_txd    (txd),
      .i_tx_valid    (tx_valid),
      .i_tx_data     (tx_data),
      .o_tx_ready    (tx_ready),
      .o_rx_valid    (rx_valid),
      .o_rx_data     (rx_data),
      .i_rx_ready    (rx_ready),
      .o_rx_frame_err(frame_err),
      .o_rx_overrun  (overrun)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [7:0]  rx_exp_q[$];
   logic [7:0]  tx_exp_q[$];
   int          cyc = 0;
   int          fall_cyc = 0, rise_cyc = 0;
   int          ovr_cnt = 0, fe_cnt = 0, exp_ovr = 0, exp_fe = 0;
   logic        valid_prev = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // RX monitor: counts pulses and compares every popped byte against the scoreboard.
   initial forever begin
      logic [31:0] exp;
      @(negedge clk);
      if (rst !== 1'b0) begin
         valid_prev = 1'b0;
      end else begin
         if (overrun)   ovr_cnt++;
         if (frame_err) fe_cnt++;
         if (rx_valid && !valid_prev) rise_cyc = cyc;
         valid_prev = rx_valid;
         if (rx_valid && rx_ready) begin
            exp = (rx_exp_q.size() != 0) ? {24'd0, rx_exp_q.pop_front()} : 32'hFFFF_FFFF;
            check_eq("rx_byte", {24'd0, rx_data}, exp);
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      fall_cyc = cyc;
      for (int k = 0; k < 10; k++) begin
         rxd = f[k];
         tick(Cpb);
      end
   endtask

   task automatic rx_send(input logic [7:0] b);
      if (rx_exp_q.size() < Depth) rx_exp_q.push_back(b);
      else                         exp_ovr++;
      send_frame(b, 1'b1);
   endtask

   task automatic tx_accept(input logic [7:0] b);
      check_eq("tx_ready_pre", {31'd0, tx_ready}, 32'd1);
      tx_valid = 1'b1;
      tx_data  = b;
      tx_exp_q.push_back(b);
      tick(1);
      tx_valid = 1'b0;
   endtask

   // Called one cycle into the start bit; samples each bit near its middle.
   task automatic tx_decode();
      logic [7:0] b;
      logic [7:0] exp;
      tick(4);
      for (int i = 0; i < 8; i++) begin
         tick(Cpb);
         b[i] = txd;
      end
      tick(Cpb);
      check_eq("tx_stop", {31'd0, txd}, 32'd1);
      exp = (tx_exp_q.size() != 0) ? tx_exp_q.pop_front() : 8'hxx;
      check_eq("tx_byte", {24'd0, b}, {24'd0, exp});
      tick(4);
   endtask

   initial begin
      logic [9:0] fr;
      logic [7:0] obs8, exp_b;
      logic [3:0] obs4;
      int         ready_low, low_cnt;

      rst = 1'b0; cts_n = 1'b0; rxd = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
      #2 rst = 1'b1;
      tick(2);
      check_eq("rst_txd", {31'd0, txd}, 32'd1);
      check_eq("rst_rts_n", {31'd0, rts_n}, 32'd1);
      check_eq("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
      check_eq("rst_rx_out", {22'd0, rx_valid, rx_data, frame_err}, 32'd0);
      rst = 1'b0;
      tick(1);
      check_eq("first_clk", {30'd0, tx_ready, rts_n}, 32'd2);
      tick(10);
      check_eq("idle", {28'd0, txd, rts_n, tx_ready, rx_valid}, 32'b1010);

      // TX 0xA5, cycle-exact
      tx_accept(8'hA5);
      ready_low = 0;
      if (!tx_ready) ready_low++;
      check_eq("tx_wait_line", {31'd0, txd}, 32'd1);
      tick(1);
      if (!tx_ready) ready_low++;
      check_eq("tx_wait_line2", {31'd0, txd}, 32'd1);
      tick(1);
      exp_b = tx_exp_q.pop_front();
      fr    = {1'b1, exp_b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < 8; j++) begin
            obs8[j] = txd;
            if (!tx_ready) ready_low++;
            tick(1);
         end
         check_eq($sformatf("tx_bit%0d", k), {24'd0, obs8}, {24'd0, {8{fr[k]}}});
      end
      check_eq("tx_ready_low", ready_low, 32'd81);

      // CTS gating
      cts_n = 1'b1;
      tick(3);
      tx_accept(8'h5A);
      low_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (!txd) low_cnt++;
         tick(1);
      end
      check_eq("cts_hold_low_cycles", low_cnt, 32'd0);
      check_eq("cts_hold_ready", {31'd0, tx_ready}, 32'd0);
      cts_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         obs4[i] = txd;
      end
      check_eq("cts_start_lat", {28'd0, obs4}, 32'b0111);
      tx_decode();

      // RX 0x3C, latency and hold until ready
      rx_send(8'h3C);
      check_eq("rx_latency", rise_cyc - fall_cyc, 32'd79);
      check_eq("rx_head", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, rx_exp_q[0]});
      tick(20);
      check_eq("rx_hold", {31'd0, rx_valid}, 32'd1);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
      tick(1);
      check_eq("rx_popped", {31'd0, rx_valid}, 32'd0);
      rxd = 1'b0;
      tick(3);
      rxd = 1'b1;
      tick(100);
      check_eq("glitch_no_byte", {31'd0, rx_valid}, 32'd0);
      check_eq("glitch_no_fe", fe_cnt, exp_fe);

      // flow control and overrun, back-to-back frames
      rx_send(8'h11);
      rx_send(8'h22);
      check_eq("rts_two", {31'd0, rts_n}, 32'd0);
      rx_send(8'h33);
      check_eq("rts_three", {31'd0, rts_n}, 32'd1);
      rx_send(8'h44);
      rx_send(8'h55);
      tick(2);
      check_eq("overrun_pulses", ovr_cnt, exp_ovr);
      check_eq("full_head", {24'd0, rx_data}, {24'd0, rx_exp_q[0]});
      rx_ready = 1'b1;
      for (int i = 0; i < 200 && rx_exp_q.size() != 0; i++) tick(1);
      check_eq("drain_done", rx_exp_q.size(), 32'd0);
      tick(2);
      check_eq("rts_drained", {30'd0, rts_n, rx_valid}, 32'd0);

      // frame error then a good frame
      send_frame(8'h77, 1'b0);
      exp_fe++;
      rxd = 1'b1;
      tick(16);
      check_eq("frame_err_pulses", fe_cnt, exp_fe);
      rx_send(8'h69);
      for (int i = 0; i < 50 && rx_exp_q.size() != 0; i++) tick(1);
      check_eq("after_fe_rx", rx_exp_q.size(), 32'd0);
      check_eq("frame_err_total", fe_cnt, exp_fe);

      // async reset mid-frame
      rx_ready = 1'b0;
      rx_send(8'hC3);
      tick(3);
      check_eq("pre_rst_rx_valid", {31'd0, rx_valid}, 32'd1);
      tx_accept(8'h00);
      tick(20);
      check_eq("pre_rst_txd", {31'd0, txd}, 32'd0);
      rst = 1'b1;
      #1;
      check_eq("rst_abort_txd", {31'd0, txd}, 32'd1);
      check_eq("rst_fifo_clear", {31'd0, rx_valid}, 32'd0);
      rx_exp_q.delete();
      tx_exp_q.delete();
      tick(1);
      rst = 1'b0;
      tick(2);
      check_eq("post_rst", {29'd0, tx_ready, rts_n, txd}, 32'b101);
      check_eq("overrun_total", ovr_cnt, exp_ovr);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1);
   end

endmodule
